// File: rtl/serial_sub_if.sv
// Host-side handshake bundle for the bit-serial subtractor: start/operands in,
// busy/done/result out.
`timescale 1ns/1ps
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff_out;
  logic             bor_out;

  modport master (
    output start, a_in, b_in,
    input  busy, done, diff_out, bor_out
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, diff_out, bor_out
  );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A-B: one full-subtract cell (two half-subtractors + OR) stepped
// LSB-first over WIDTH cycles; result and final borrow held until next completion.
//
//  state  | meaning
//  IDLE   | waiting for start, operands captured on accept
//  RUN    | one bit per edge, WIDTH edges
//  DONE   | one-cycle done pulse, then back to IDLE unconditionally
`timescale 1ns/1ps
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    cnt;
  logic             bflop;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bor_q;

  // full-subtract cell built from two half-subtractor stages
  logic abit, bbit, d1, b1, dbit, b2, bout;

  always_comb begin
    abit = a_sh[0];
    bbit = b_sh[0];
    d1   = abit ^ bbit;
    b1   = ~abit & bbit;
    dbit = d1 ^ bflop;
    b2   = ~d1 & bflop;
    bout = b1 | b2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      cnt    <= '0;
      bflop  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bor_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a_in;
            b_sh   <= bus.b_in;
            cnt    <= '0;
            bflop  <= 1'b0;
            busy_q <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_sh  <= {dbit, r_sh[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          bflop <= bout;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            // last bit goes straight into the result so it lands on the DONE-entry edge
            diff_q <= {dbit, r_sh[WIDTH-1:1]};
            bor_q  <= bout;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.diff_out = diff_q;
  assign bus.bor_out  = bor_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomized self-checking bench for serial_sub_ctrl at WIDTH=8 and an
// exhaustive WIDTH=4 sweep against an arithmetic reference.
`timescale 1ns/1ps
module tb_serial_sub_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [7:0] last_diff8 = 8'h00;

  serial_sub_if #(.WIDTH(8)) bus8 ();
  serial_sub_if #(.WIDTH(4)) bus4 ();

  serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_sub_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  always @(negedge clk)
    if (!rst) begin
      chk("busy_done_excl8", 32'(bus8.busy & bus8.done), 32'd0);
      chk("busy_done_excl4", 32'(bus4.busy & bus4.done), 32'd0);
    end

  // one WIDTH=8 operation; disturb pulses start and scrambles operands mid-RUN
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit disturb);
    logic [7:0] ed;
    logic       ebor;
    int         cyc;
    bit         seen;
    ed   = a - b;
    ebor = (a < b);
    bus8.a_in  = a;
    bus8.b_in  = b;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    chk("busy_on_accept", 32'(bus8.busy), 32'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      if (disturb && (cyc == 2 || cyc == 4)) begin
        bus8.start = 1'b1;
        bus8.a_in  = 8'($urandom);
        bus8.b_in  = 8'($urandom);
      end else begin
        bus8.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (bus8.done) seen = 1'b1;
      else begin
        chk("busy_in_run", 32'(bus8.busy), 32'd1);
        chk("diff_stable", 32'(bus8.diff_out), 32'(last_diff8));
      end
    end
    bus8.start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(cyc), 32'd8);
    chk("diff", 32'(bus8.diff_out), 32'(ed));
    chk("bor", 32'(bus8.bor_out), 32'(ebor));
    chk("busy_in_done", 32'(bus8.busy), 32'd0);
    last_diff8 = ed;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_extra_done", 32'(bus8.done), 32'd0);
      chk("idle_busy", 32'(bus8.busy), 32'd0);
    end
    chk("diff_held", 32'(bus8.diff_out), 32'(ed));
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    int cyc;
    bus4.a_in  = a;
    bus4.b_in  = b;
    bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    cyc = 0;
    while (!bus4.done && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("w4_latency", 32'(cyc), 32'd4);
    chk("w4_diff", 32'(bus4.diff_out), 32'((a - b) & 4'hF));
    chk("w4_bor", 32'(bus4.bor_out), 32'(a < b));
    @(posedge clk); #1;
  endtask

  initial begin
    int n_done;
    int done_at[$];
    int first_done;

    bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0;
    bus4.start = 1'b0; bus4.a_in = '0; bus4.b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_done", 32'(bus8.done), 32'd0);
    chk("rst_diff", 32'(bus8.diff_out), 32'd0);
    chk("rst_bor", 32'(bus8.bor_out), 32'd0);
    chk("rst_diff4", 32'(bus4.diff_out), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    op8(8'h5A, 8'h3C, 1'b0);
    op8(8'h00, 8'h01, 1'b0);
    op8(8'h80, 8'h80, 1'b0);
    op8(8'h10, 8'h01, 1'b1);
    op8(8'hFF, 8'h00, 1'b0);
    op8(8'h00, 8'hFF, 1'b0);

    // abort mid-RUN: outputs clear asynchronously, no done pulse follows
    bus8.a_in = 8'h5A; bus8.b_in = 8'h3C; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus8.busy), 32'd0);
    chk("abort_diff", 32'(bus8.diff_out), 32'd0);
    chk("abort_bor", 32'(bus8.bor_out), 32'd0);
    chk("abort_done", 32'(bus8.done), 32'd0);
    last_diff8 = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus8.done) n_done++;
    end
    chk("abort_no_done", 32'(n_done), 32'd0);
    op8(8'h5A, 8'h3C, 1'b0);

    // start tied high: back-to-back ops every WIDTH+2 cycles
    bus8.a_in = 8'h33; bus8.b_in = 8'h44; bus8.start = 1'b1;
    first_done = -1;
    for (int n = 1; n <= 60 && done_at.size() < 3; n++) begin
      @(posedge clk); #1;
      if (first_done >= 0)
        chk("b2b_busy", 32'(bus8.busy), 32'(((n - first_done) % 10) >= 2));
      if (bus8.done) begin
        done_at.push_back(n);
        if (first_done < 0) first_done = n;
        chk("b2b_diff", 32'(bus8.diff_out), 32'h0000_00EF);
        chk("b2b_bor", 32'(bus8.bor_out), 32'd1);
      end
    end
    bus8.start = 1'b0;
    chk("b2b_count", 32'(done_at.size()), 32'd3);
    if (done_at.size() == 3) begin
      chk("b2b_first", 32'(done_at[0]), 32'd9);
      chk("b2b_gap1", 32'(done_at[1] - done_at[0]), 32'd10);
      chk("b2b_gap2", 32'(done_at[2] - done_at[1]), 32'd10);
    end
    last_diff8 = 8'hEF;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++)
      op8(8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        op4(4'(a), 4'(b));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule
